ex_wb_stage: RTL
================

// Module: ex_wb_stage
// PURPOSE
//  Execute-to-writeback stage, directly downstream of the combinational execute block.
//  Registers the execute result and owns the architectural CPSR (N,C,Z,V).
//  Runs the load/store data-memory handshake.
//  Drives the single register-file write port.
// PARAMETERS
//  DATA_W       32   datapath width; ex_result is DATA_W+1 (bit DATA_W = carry)
//  REG_ADDR_W   3    register-file address width (8 registers)
//  MEM_TIMEOUT  255  max cycles waiting for mem_ack before abort
// PORTS
//  clk            in   1            single clock, rising edge
//  rst_n          in   1            synchronous reset, active low
//  ex_valid       in   1            execute output valid this cycle
//  ex_ready       out  1            stage can accept; transfer = ex_valid & ex_ready
//  ex_result      in   DATA_W+1     execute result, bit DATA_W = carry out
//  ex_dest_reg    in   REG_ADDR_W   destination register
//  ex_wen         in   1            instruction writes a register
//  ex_set_flags   in   1            instruction updates CPSR
//  ex_flags       in   4            {N,C,Z,V} computed by execute
//  ex_mem_op      in   2            00 none, 01 load, 10 store, 11 reserved
//  ex_addr        in   DATA_W       memory address for load/store
//  ex_store_data  in   DATA_W       store data
//  flush          in   1            kill current/incoming instruction (branch taken)
//  mem_req        out  1            memory request, held until mem_ack or timeout
//  mem_we         out  1            1 = store, 0 = load; valid while mem_req
//  mem_addr       out  DATA_W       registered address
//  mem_wdata      out  DATA_W       registered store data
//  mem_rdata      in   DATA_W       load data, sampled on the mem_ack cycle
//  mem_ack        in   1            one-cycle completion pulse
//  rf_wen         out  1            register-file write strobe, one cycle
//  rf_waddr       out  REG_ADDR_W   write address
//  rf_wdata       out  DATA_W       write data
//  cpsr           out  4            {N,C,Z,V}
//  mem_err        out  1            sticky memory-timeout error
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state IDLE, all outputs 0, cpsr=4'b0000, mem_err=0.
//  Reset mid-memory access drops mem_req immediately, with no writeback.
//  States: IDLE, MEM. ex_ready = (state==IDLE) & ~flush.
//  IDLE, transfer with ex_mem_op=00:
//   - rf_wen=ex_wen at the next edge, rf_waddr=ex_dest_reg, rf_wdata=ex_result[DATA_W-1:0].
//   - Latency is 1 cycle; full throughput (back-to-back transfers give back-to-back rf_wen).
//   - If ex_set_flags=1, cpsr<=ex_flags at the same edge; otherwise cpsr is held.
//   - ex_result[DATA_W] is never written to a register.
//  IDLE, transfer with ex_mem_op=01/10:
//   - Latch address, data and dest register; mem_req=1 and mem_we=op[1] from the next cycle.
//   - Go to MEM and clear the timeout counter.
//   - ex_set_flags is ignored for memory ops.
//  IDLE, transfer with ex_mem_op=11: no write, no flag update, no memory access.
//  MEM:
//   - The counter increments each cycle.
//   - On mem_ack: mem_req=0 at the next edge, state IDLE.
//   - Load with ex_wen: rf_wen=1 with rf_wdata=mem_rdata at that same edge.
//   - Store: no rf write.
//   - If the counter reaches MEM_TIMEOUT without mem_ack: mem_req=0, mem_err=1 (sticky until reset), IDLE, no write.
//   - mem_ack arriving while in IDLE is ignored.
//  flush:
//   - Blocks acceptance in the flush cycle.
//   - In MEM, the outstanding request still completes (bus rule) but its writeback is suppressed.
//   - A flush already registered in MEM is remembered until completion.
//   - flush never alters cpsr or an rf_wen already issued.
//  rf_wen deasserts the cycle after any write unless a new write follows.
// TESTING
//  1 Reset: hold rst_n=0 2 cycles -> every output 0, cpsr=0000, ex_ready=1 after release.
//  2 ALU back-to-back:
//    - Stimulus: cycle0 result=0x1_0000_0005 dest=3 wen=1 setf=1 flags=0110; cycle1 result=7 dest=4.
//    - Response: cycle1 rf_wen=1 waddr=3 wdata=0x00000005, cpsr=0110; cycle2 rf_wen=1 waddr=4 wdata=7.
//  3 Load, ack after 3 cycles with rdata=0xDEADBEEF dest=2:
//    - ex_ready=0 during the wait and mem_req held 3 cycles.
//    - Next edge: rf_wen=1 waddr=2 wdata=0xDEADBEEF.
//  4 Store addr=0x40 data=0x55, flush pulsed while waiting:
//    - mem_we=1 and mem_addr=0x40 held until ack.
//    - No rf_wen; cpsr unchanged.
//  5 Load with no ack, MEM_TIMEOUT=4: mem_req drops after 4 cycles, mem_err=1 persists, no rf_wen.
//  6 rst_n low during a pending load: mem_req=0 next edge, no write, state IDLE.

Source files
------------

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: execute-to-writeback stage.
//  Registers the execute result, owns the architectural CPSR {N,C,Z,V},
//  runs the load/store data-memory handshake and drives the single
//  register-file write port.
// Ports:
//  clk_i, rst_n_i                 clock, synchronous active-low reset
//  ex_*_i / ex_ready_o            execute handshake and instruction fields
//  flush_i                        kill current/incoming instruction
//  mem_req_o .. mem_ack_i         data-memory request/ack handshake
//  rf_wen_o, rf_waddr_o, rf_wdata_o  register-file write port
//  cpsr_o                         {N,C,Z,V}
//  mem_err_o                      sticky memory-timeout error
module ex_wb_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_W:0]       ex_result_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_reg_i,
  input  logic                  ex_wen_i,
  input  logic                  ex_set_flags_i,
  input  logic [3:0]            ex_flags_i,
  input  logic [1:0]            ex_mem_op_i,
  input  logic [DATA_W-1:0]     ex_addr_i,
  input  logic [DATA_W-1:0]     ex_store_data_i,
  input  logic                  flush_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  rf_wen_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [DATA_W-1:0]     rf_wdata_o,
  output logic [3:0]            cpsr_o,
  output logic                  mem_err_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, MEM = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [DATA_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdat_q, wdat_d;
  logic [REG_ADDR_W-1:0]   dest_q, dest_d;
  logic                    ld_wen_q, ld_wen_d;   // pending load that writes a register
  logic                    kill_q, kill_d;       // flush seen while in MEM
  logic                    rf_wen_q, rf_wen_d;
  logic [REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]       rf_wdata_q, rf_wdata_d;
  logic [3:0]              cpsr_q, cpsr_d;
  logic                    err_q, err_d;
  logic                    xfer;

  // The carry bit only feeds the flags computed upstream; never written back.
  logic unused_carry;
  assign unused_carry = ex_result_i[DATA_W];

  assign ex_ready_o = (state_q == IDLE) & ~flush_i;
  assign xfer       = ex_valid_i & ex_ready_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    dest_d     = dest_q;
    ld_wen_d   = ld_wen_q;
    kill_d     = kill_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    cpsr_d     = cpsr_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          case (ex_mem_op_i)
            2'b00: begin
              rf_wen_d   = ex_wen_i;
              rf_waddr_d = ex_dest_reg_i;
              rf_wdata_d = ex_result_i[DATA_W-1:0];
              if (ex_set_flags_i) cpsr_d = ex_flags_i;
            end
            2'b01, 2'b10: begin
              addr_d   = ex_addr_i;
              wdat_d   = ex_store_data_i;
              dest_d   = ex_dest_reg_i;
              ld_wen_d = ex_wen_i & ~ex_mem_op_i[1];
              kill_d   = 1'b0;
              req_d    = 1'b1;
              we_d     = ex_mem_op_i[1];
              cnt_d    = '0;
              state_d  = MEM;
            end
            default: ;  // reserved op: dropped silently
          endcase
        end
      end
      MEM: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) kill_d = 1'b1;
        if (mem_ack_i) begin
          req_d   = 1'b0;
          state_d = IDLE;
          // Bus transfer completes regardless; only the writeback is killed.
          if (ld_wen_q && !kill_q && !flush_i) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = dest_q;
            rf_wdata_d = mem_rdata_i;
          end
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          // Request has been held MEM_TIMEOUT cycles with no ack.
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      dest_q     <= '0;
      ld_wen_q   <= 1'b0;
      kill_q     <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cpsr_q     <= 4'b0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      dest_q     <= dest_d;
      ld_wen_q   <= ld_wen_d;
      kill_q     <= kill_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cpsr_q     <= cpsr_d;
      err_q      <= err_d;
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdat_q;
  assign rf_wen_o    = rf_wen_q;
  assign rf_waddr_o  = rf_waddr_q;
  assign rf_wdata_o  = rf_wdata_q;
  assign cpsr_o      = cpsr_q;
  assign mem_err_o   = err_q;

endmodule
